// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP) sharing one memory port.
// Latency: 3 cycles branch, 4 store/ALU/lui/jal, 5 load, plus memory wait cycles; strobes are combinational.
// Backpressure: FETCH/MEM hold mem_req until mem_ready; WAIT_MAX unanswered cycles traps (sticky timeout).
//
// Ports:
//   clk, rstn            clock (rising edge), async active-low reset
//   Op, Funct3, Zero     instruction fields / ALU branch condition
//   mem_ready            memory completes the current access this cycle
//   mem_req/mem_we/IorD  shared memory port handshake and address select
//   IRWrite, PCWrite     instruction register load, PC update (NPCOp selects next PC)
//   RegWrite, WDSel      register file write and write-data source
//   ALUSrcA, ALUSrcB     ALU operand selects
//   state                current state code (debug)
//   illegal, timeout     sticky trap causes
//   instret              retired-instruction count, wraps modulo 2^CNT_W
module mc_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       Op,
  input  logic [2:0]       Funct3,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [2:0]       NPCOp,
  output logic             RegWrite,
  output logic [1:0]       WDSel,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // The wait counter only needs to hold 0..WAIT_MAX-1: the WAIT_MAX-th
  // unanswered cycle is detected by comparing against WAIT_MAX-1.
  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_lui, is_legal;
  logic wait_expired;

  // Funct3 never affects sequencing; legality is decided by Op alone.
  logic unused_funct3;
  assign unused_funct3 = ^Funct3;

  assign is_r     = (Op == OP_R);
  assign is_i     = (Op == OP_I);
  assign is_ld    = (Op == OP_LD);
  assign is_st    = (Op == OP_ST);
  assign is_br    = (Op == OP_BR);
  assign is_jal   = (Op == OP_JAL);
  assign is_lui   = (Op == OP_LUI);
  assign is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_lui;

  assign wait_expired = (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;            // any cycle not stalling in FETCH/MEM clears it
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    NPCOp     = 3'b000;
    RegWrite  = 1'b0;
    WDSel     = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (is_i | is_ld | is_st | is_lui) ALUSrcB = 2'b10;
        if (is_br) begin
          PCWrite = 1'b1;
          NPCOp   = Zero ? 3'b001 : 3'b000;
          state_d = S_FETCH;
        end else if (is_ld | is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        mem_we  = is_st;
        if (mem_ready) begin
          if (is_st) begin
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        if (is_ld)       WDSel = 2'b01;
        else if (is_jal) WDSel = 2'b10;
        if (is_jal) NPCOp = 3'b010;
        state_d = S_FETCH;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_IDLE;
    endcase
  end

  // Retirement coincides exactly with the PC update.
  assign instret_d = PCWrite ? (instret_q + CNT_W'(1)) : instret_q;

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed vector table, hand-written corner sequences and a
// randomized run compared against an instruction-route reference model.
module tb_mc_ctrl;

  localparam int WM = 16;
  localparam int CW = 5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  localparam int PH_F = 1, PH_D = 2, PH_E = 3, PH_M = 4, PH_W = 5, PH_T = 7;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [6:0]    op = OP_I;
  logic [2:0]    f3 = 3'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, ALUSrcA;
  logic [2:0]    NPCOp, state;
  logic [1:0]    WDSel, ALUSrcB;
  logic          illegal, timeout;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  mc_ctrl #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .Op(op), .Funct3(f3), .Zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .NPCOp(NPCOp), .RegWrite(RegWrite),
    .WDSel(WDSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .state(state),
    .illegal(illegal), .timeout(timeout), .instret(instret)
  );

  typedef struct {
    logic [6:0]    op;
    logic          zero;
    logic          rdy;
    logic [2:0]    st;
    logic          req, we, iord, irw, pcw;
    logic [2:0]    npc;
    logic          rw;
    logic [1:0]    wd;
    logic          sa;
    logic [1:0]    sb;
    logic          ill, tmo;
    logic [CW-1:0] ir;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] ctl_now();
    return {mem_req, mem_we, IorD, IRWrite, PCWrite, NPCOp, RegWrite, WDSel, ALUSrcA, ALUSrcB};
  endfunction

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, " ctl{req,we,iord,irw,pcw,npc,rw,wd,sa,sb}"}, 32'(ctl_now()),
        32'({v.req, v.we, v.iord, v.irw, v.pcw, v.npc, v.rw, v.wd, v.sa, v.sb}));
    chk({tag, " state"}, 32'(state), 32'(v.st));
    chk({tag, " illegal,timeout"}, 32'({illegal, timeout}), 32'({v.ill, v.tmo}));
    chk({tag, " instret"}, 32'(instret), 32'(v.ir));
  endtask

  // Drive one cycle's inputs on the falling edge, check the settled outputs.
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    op = v.op; zero = v.zero; mem_ready = v.rdy; f3 = 3'($urandom_range(0, 7));
    #1;
    check_outs(tag, v);
  endtask

  // Assert reset mid-cycle, check everything is quiet, release just after a rising edge.
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("reset state", 32'(state), 32'd0);
    chk("reset ctl", 32'(ctl_now()), 32'd0);
    chk("reset flags", 32'({illegal, timeout}), 32'd0);
    chk("reset instret", 32'(instret), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  function automatic vec_t blank(input logic [6:0] o, input logic z, input logic r,
                                 input logic [2:0] st, input logic [CW-1:0] ir);
    vec_t v;
    v = '{default: '0};
    v.op = o; v.zero = z; v.rdy = r; v.st = st; v.ir = ir;
    return v;
  endfunction

  function automatic vec_t v_idle(input logic [6:0] o, input logic [CW-1:0] ir);
    return blank(o, 1'b0, 1'b1, 3'd0, ir);
  endfunction

  function automatic vec_t v_fetch(input logic [6:0] o, input logic r, input logic [CW-1:0] ir);
    vec_t v;
    v = blank(o, 1'b0, r, 3'd1, ir);
    v.req = 1'b1; v.irw = r;
    return v;
  endfunction

  function automatic vec_t v_dec(input logic [6:0] o, input logic [CW-1:0] ir);
    return blank(o, 1'b0, 1'b1, 3'd2, ir);
  endfunction

  function automatic vec_t v_exec(input logic [6:0] o, input logic z, input logic [1:0] sb,
                                  input logic pcw, input logic [2:0] npc, input logic [CW-1:0] ir);
    vec_t v;
    v = blank(o, z, 1'b1, 3'd3, ir);
    v.sa = 1'b1; v.sb = sb; v.pcw = pcw; v.npc = npc;
    return v;
  endfunction

  function automatic vec_t v_mem(input logic [6:0] o, input logic r, input logic we,
                                 input logic pcw, input logic [CW-1:0] ir);
    vec_t v;
    v = blank(o, 1'b0, r, 3'd4, ir);
    v.req = 1'b1; v.iord = 1'b1; v.we = we; v.pcw = pcw;
    return v;
  endfunction

  function automatic vec_t v_wb(input logic [6:0] o, input logic [1:0] wd,
                                input logic [2:0] npc, input logic [CW-1:0] ir);
    vec_t v;
    v = blank(o, 1'b0, 1'b1, 3'd5, ir);
    v.rw = 1'b1; v.pcw = 1'b1; v.wd = wd; v.npc = npc;
    return v;
  endfunction

  // ---------------- reference model: each instruction is a route of phases ----------------
  int            route[$];
  int            idx;
  int            waited;
  bit            m_idle, m_trap, m_ill, m_tmo;
  logic [CW-1:0] m_ir;
  logic [6:0]    cur_op;

  function automatic bit legal(input logic [6:0] o);
    return o inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_LUI};
  endfunction

  task automatic new_instr();
    logic [6:0] pick[7];
    pick = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_LUI};
    if ($urandom_range(0, 24) == 0) begin
      cur_op = 7'($urandom_range(0, 127));
      while (legal(cur_op)) cur_op = 7'($urandom_range(0, 127));
    end else begin
      cur_op = pick[$urandom_range(0, 6)];
    end
    route.delete();
    route.push_back(PH_F);
    route.push_back(PH_D);
    if (!legal(cur_op)) begin
      route.push_back(PH_T);
    end else begin
      route.push_back(PH_E);
      if (cur_op == OP_LD || cur_op == OP_ST) route.push_back(PH_M);
      if (!(cur_op == OP_ST || cur_op == OP_BR)) route.push_back(PH_W);
    end
    idx = 0;
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_trap = 1'b0; m_ill = 1'b0; m_tmo = 1'b0;
    m_ir = '0; waited = 0; idx = 0; cur_op = OP_I;
    route.delete();
  endtask

  task automatic model_cycle(input logic z, input logic r, output vec_t e);
    int ph;
    bit ld, st, br, jal;
    ph  = m_idle ? 0 : (m_trap ? PH_T : route[idx]);
    ld  = (cur_op == OP_LD); st = (cur_op == OP_ST);
    br  = (cur_op == OP_BR); jal = (cur_op == OP_JAL);
    e = blank(cur_op, z, r, ph[2:0], m_ir);
    e.ill = m_ill; e.tmo = m_tmo;
    case (ph)
      PH_F: begin e.req = 1'b1; e.irw = r; end
      PH_E: begin
        e.sa = 1'b1;
        e.sb = (cur_op inside {OP_I, OP_LD, OP_ST, OP_LUI}) ? 2'b10 : 2'b00;
        if (br) begin e.pcw = 1'b1; e.npc = z ? 3'b001 : 3'b000; end
      end
      PH_M: begin e.req = 1'b1; e.iord = 1'b1; e.we = st; e.pcw = r & st; end
      PH_W: begin
        e.rw = 1'b1; e.pcw = 1'b1;
        e.wd = ld ? 2'b01 : (jal ? 2'b10 : 2'b00);
        e.npc = jal ? 3'b010 : 3'b000;
      end
      default: ;
    endcase
    // advance the model to the next cycle
    if (m_idle) begin
      m_idle = 1'b0;
      new_instr();
    end else if (!m_trap) begin
      if ((ph == PH_F || ph == PH_M) && !r) begin
        waited++;
        if (waited == WM) begin m_trap = 1'b1; m_tmo = 1'b1; end
      end else begin
        waited = 0;
        if (e.pcw) m_ir = m_ir + 1'b1;
        idx++;
        if (idx == route.size()) new_instr();
        else if (route[idx] == PH_T) begin m_trap = 1'b1; m_ill = 1'b1; end
      end
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[$];
  vec_t v;

  initial begin
    // directed table: addi, lw with 3 wait cycles, beq taken/not, jal, sw, lui, add
    tbl.push_back(v_idle(OP_I, 0));
    tbl.push_back(v_fetch(OP_I, 1, 0));
    tbl.push_back(v_dec(OP_I, 0));
    tbl.push_back(v_exec(OP_I, 0, 2'b10, 0, 3'b000, 0));
    tbl.push_back(v_wb(OP_I, 2'b00, 3'b000, 0));
    tbl.push_back(v_fetch(OP_LD, 1, 1));
    tbl.push_back(v_dec(OP_LD, 1));
    tbl.push_back(v_exec(OP_LD, 0, 2'b10, 0, 3'b000, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(v_mem(OP_LD, 0, 0, 0, 1));
    tbl.push_back(v_mem(OP_LD, 1, 0, 0, 1));
    tbl.push_back(v_wb(OP_LD, 2'b01, 3'b000, 1));
    tbl.push_back(v_fetch(OP_BR, 1, 2));
    tbl.push_back(v_dec(OP_BR, 2));
    tbl.push_back(v_exec(OP_BR, 1, 2'b00, 1, 3'b001, 2));
    tbl.push_back(v_fetch(OP_BR, 1, 3));
    tbl.push_back(v_dec(OP_BR, 3));
    tbl.push_back(v_exec(OP_BR, 0, 2'b00, 1, 3'b000, 3));
    tbl.push_back(v_fetch(OP_JAL, 1, 4));
    tbl.push_back(v_dec(OP_JAL, 4));
    tbl.push_back(v_exec(OP_JAL, 0, 2'b00, 0, 3'b000, 4));
    tbl.push_back(v_wb(OP_JAL, 2'b10, 3'b010, 4));
    tbl.push_back(v_fetch(OP_ST, 1, 5));
    tbl.push_back(v_dec(OP_ST, 5));
    tbl.push_back(v_exec(OP_ST, 0, 2'b10, 0, 3'b000, 5));
    tbl.push_back(v_mem(OP_ST, 0, 1, 0, 5));
    tbl.push_back(v_mem(OP_ST, 1, 1, 1, 5));
    tbl.push_back(v_fetch(OP_LUI, 1, 6));
    tbl.push_back(v_dec(OP_LUI, 6));
    tbl.push_back(v_exec(OP_LUI, 0, 2'b10, 0, 3'b000, 6));
    tbl.push_back(v_wb(OP_LUI, 2'b00, 3'b000, 6));
    tbl.push_back(v_fetch(OP_R, 1, 7));
    tbl.push_back(v_dec(OP_R, 7));
    tbl.push_back(v_exec(OP_R, 0, 2'b00, 0, 3'b000, 7));
    tbl.push_back(v_wb(OP_R, 2'b00, 3'b000, 7));
    tbl.push_back(v_fetch(OP_R, 1, 8));

    do_reset();
    foreach (tbl[i]) step($sformatf("tbl[%0d]", i), tbl[i]);

    // illegal opcode: trap after DECODE, quiet for 20 cycles
    do_reset();
    step("ill idle", v_idle(OP_SYS, 0));
    step("ill fetch", v_fetch(OP_SYS, 1, 0));
    step("ill decode", v_dec(OP_SYS, 0));
    for (int i = 0; i < 20; i++) begin
      v = blank(OP_SYS, 1'b1, 1'b1, 3'd7, 0);
      v.ill = 1'b1;
      step($sformatf("ill trap[%0d]", i), v);
    end

    // fetch timeout after exactly WM unanswered cycles
    do_reset();
    step("tmo idle", v_idle(OP_I, 0));
    for (int i = 0; i < WM; i++) step($sformatf("tmo fetch[%0d]", i), v_fetch(OP_I, 0, 0));
    for (int i = 0; i < 4; i++) begin
      v = blank(OP_I, 1'b0, 1'b1, 3'd7, 0);
      v.tmo = 1'b1;
      step($sformatf("tmo trap[%0d]", i), v);
    end

    // ready on the WM-th cycle completes normally
    do_reset();
    step("edge idle", v_idle(OP_I, 0));
    for (int i = 0; i < WM - 1; i++) step($sformatf("edge fetch[%0d]", i), v_fetch(OP_I, 0, 0));
    step("edge fetch last", v_fetch(OP_I, 1, 0));
    step("edge decode", v_dec(OP_I, 0));
    step("edge exec", v_exec(OP_I, 0, 2'b10, 0, 3'b000, 0));

    // reset pulse in the middle of a stalled store
    do_reset();
    step("rs idle", v_idle(OP_I, 0));
    step("rs fetch", v_fetch(OP_I, 1, 0));
    step("rs decode", v_dec(OP_I, 0));
    step("rs exec", v_exec(OP_I, 0, 2'b10, 0, 3'b000, 0));
    step("rs wb", v_wb(OP_I, 2'b00, 3'b000, 0));
    step("rs st fetch", v_fetch(OP_ST, 1, 1));
    step("rs st decode", v_dec(OP_ST, 1));
    step("rs st exec", v_exec(OP_ST, 0, 2'b10, 0, 3'b000, 1));
    step("rs st mem", v_mem(OP_ST, 0, 1, 0, 1));
    do_reset();
    step("rs after idle", v_idle(OP_ST, 0));
    step("rs after fetch", v_fetch(OP_ST, 0, 0));

    // randomized episodes against the route model
    for (int ep = 0; ep < 12; ep++) begin
      int stall;
      bit long_stalls;
      logic z, r;
      vec_t e;
      do_reset();
      model_reset();
      stall = 0;
      long_stalls = (ep % 3 == 2);
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (stall == 0 && $urandom_range(0, 7) == 0)
          stall = long_stalls ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 8));
        r = (stall == 0);
        if (stall > 0) stall--;
        z = 1'($urandom_range(0, 1));
        op = cur_op; zero = z; mem_ready = r; f3 = 3'($urandom_range(0, 7));
        #1;
        model_cycle(z, r, e);
        check_outs($sformatf("rnd ep%0d c%0d", ep, c), e);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
